fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the 16-bit MIPS core. It owns the program counter, issues one-outstanding-request fetches to instruction memory, and holds the IF/ID pipeline register whose `if_id_instr` output feeds the instruction field decoder in ID. It also handles ID-stage stall, jump redirects built from the 13-bit J-format address field, and branch redirects from later stages. Instruction memory is word-addressed, so the PC advances by 1 per instruction.

## Interface
- `inst_SIZE`, 16, instruction width in bits.
- `PC_WIDTH`, 16, program counter width.
- `RESET_PC`, 16'h0000, first fetch address after reset.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req` output 1: fetch request; held high until `imem_ack`.
- `imem_addr` output PC_WIDTH: fetch address; stable while `imem_req` is high.
- `imem_ack` input 1: response strobe. May assert in the same cycle `imem_req` first rises. `imem_rdata` is valid in that cycle.
- `imem_rdata` input inst_SIZE: fetched instruction.
- `id_stall` input 1: ID cannot accept a new instruction; hold IF/ID.
- `jump_valid` input 1: ID decoded a jump this cycle.
- `jump_addr` input 13: J-format address field.
- `br_valid` input 1: branch redirect from a later stage.
- `br_target` input PC_WIDTH: branch target.
- `if_id_instr` output inst_SIZE: IF/ID instruction register.
- `if_id_pc` output PC_WIDTH: address of `if_id_instr`.
- `if_id_pc_plus1` output PC_WIDTH: `if_id_pc + 1`, mod 2^PC_WIDTH.
- `if_id_valid` output 1: IF/ID holds a live instruction.

## Operation
- **Reset values:** state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_pc_plus1=0, if_id_valid=0, skid buffer empty.
- **Redirect target:** `br_valid` has priority, giving target=`br_target`. Otherwise `jump_valid` gives target=`{if_id_pc_plus1[15:13], jump_addr}`. `redir` = `br_valid | jump_valid`.
- **Accept condition:** `accept` = `!id_stall | !if_id_valid`.
- **redir flush:** clears `if_id_valid` on that edge. This happens in every state and overrides `id_stall`.
- **IDLE:** no request. Next state is FETCH, with `imem_addr` = pc.
- **FETCH:** `imem_req`=1, `imem_addr`=pc.
  - `redir` and `imem_ack` together: discard data, pc=target, stay in FETCH.
  - `redir` without `imem_ack`: latch target and go to DRAIN. The address must not change while the request is outstanding.
  - `imem_ack` with `accept`: load IF/ID with {rdata, pc, pc+1}, set valid=1, pc=pc+1, stay in FETCH.
  - `imem_ack` without `accept`: store rdata in the skid buffer, go to HOLD, drop `imem_req`.
- **DRAIN:** `imem_req`=1 with the old address.
  - On `imem_ack`: discard data, pc=latched target, go to FETCH.
  - A further `redir` during DRAIN overwrites the latched target.
- **HOLD:** `imem_req`=0.
  - `redir`: drop the skid buffer, pc=target, go to FETCH.
  - `accept`: move the skid buffer into IF/ID, pc=pc+1, go to FETCH.
- **PC arithmetic:** wraps modulo 2^PC_WIDTH; 16'hFFFF + 1 = 16'h0000.
- **Response filtering:** `imem_ack` is ignored in IDLE and HOLD.
- **Reset mid-request:** the request is abandoned. Instruction memory shares `rst` and must drop it too.

## Timing
- After `rst` deasserts, cycle 0 is IDLE. Cycle 1 has `imem_req`=1 with `imem_addr`=RESET_PC.
- With a zero-wait memory (ack in the request cycle), `if_id_valid`=1 after the cycle-1 edge.
- Sustained throughput is one instruction per cycle with zero-wait memory and no stalls.
- Redirect penalty, zero-wait memory: the redirect edge loads the target into pc. The target is requested the next cycle and is in IF/ID one edge later.
- Redirect with an outstanding request: the penalty is extended by the remaining memory latency (DRAIN).
- `if_id_*` change only on accept, flush, or reset. While stalled and not flushed they hold exactly.
- No combinational path from `imem_rdata` to any output.

## Test plan
- **Reset / sequential fetch:** reset, then zero-wait memory returning `mem[a]=a^16'hA5A5`, no stall -> `if_id_pc` = 0,1,2,3 on consecutive edges, `if_id_instr` matching, `if_id_valid` continuous from the second edge.
- **Stall / skid:** `id_stall`=1 for 3 cycles while IF/ID holds pc=2, with the ack for pc=3 arriving -> HOLD, `imem_req`=0, IF/ID unchanged. After stall release, IF/ID becomes pc=3 and the next request is addr 4. No instruction is lost or duplicated.
- **Jump:** `jump_valid` with `jump_addr`=13'h0123 while `if_id_pc_plus1`=16'h4005 -> `if_id_valid`=0 next edge. Next request addr is 16'h4123, then `if_id_pc`=16'h4123.
- **Branch during outstanding request:** 3-cycle memory latency, `br_valid` with `br_target`=16'h0040 in the first request cycle -> `imem_addr` stays at the old pc until ack, that data is discarded, and the next request is 16'h0040.
- **Simultaneous redirects:** `br_valid` (16'h0080) with `jump_valid` in the same cycle -> branch wins, next fetch is 16'h0080.
- **Wrap and async reset:** pc=16'hFFFF fetched -> next `imem_addr`=16'h0000. Asserting `rst` mid-DRAIN -> all outputs reach their reset values immediately, without waiting for `clk`.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding fetches and
// holds the IF/ID register, with stall skid buffering and jump/branch redirects.
//
// state | meaning
// IDLE  | first cycle after reset, no request
// FETCH | request outstanding at pc
// DRAIN | redirect seen mid-request; wait for the stale ack, then go to redir_pc
// HOLD  | fetched word parked in skid buffer while ID is stalled
module fetch_stage #(
  parameter int inst_SIZE = 16,
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [inst_SIZE-1:0] imem_rdata,
  input  logic                 id_stall,
  input  logic                 jump_valid,
  input  logic [12:0]          jump_addr,
  input  logic                 br_valid,
  input  logic [PC_WIDTH-1:0]  br_target,
  output logic [inst_SIZE-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]  if_id_pc,
  output logic [PC_WIDTH-1:0]  if_id_pc_plus1,
  output logic                 if_id_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state;
  logic [PC_WIDTH-1:0]  pc;
  logic [PC_WIDTH-1:0]  redir_pc;
  logic [inst_SIZE-1:0] skid;

  logic                 redir;
  logic [PC_WIDTH-1:0]  target;
  logic                 accept;
  logic                 load;
  logic [inst_SIZE-1:0] load_instr;

  assign redir  = br_valid | jump_valid;
  assign target = br_valid ? br_target
                           : {if_id_pc_plus1[PC_WIDTH-1:13], jump_addr};
  assign accept = !id_stall | !if_id_valid;

  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = pc;

  // A redirect always wins over loading a fresh or parked instruction.
  always_comb begin
    load       = 1'b0;
    load_instr = imem_rdata;
    if (!redir && accept) begin
      if (state == FETCH && imem_ack) begin
        load = 1'b1;
      end else if (state == HOLD) begin
        load       = 1'b1;
        load_instr = skid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      redir_pc <= RESET_PC;
      skid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redir) pc <= target;
        end
        FETCH: begin
          if (redir) begin
            if (imem_ack) begin
              pc <= target;
            end else begin
              redir_pc <= target;
              state    <= DRAIN;
            end
          end else if (imem_ack) begin
            if (accept) begin
              pc <= pc + PC_ONE;
            end else begin
              skid  <= imem_rdata;
              state <= HOLD;
            end
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc    <= redir ? target : redir_pc;
            state <= FETCH;
          end else if (redir) begin
            redir_pc <= target;
          end
        end
        HOLD: begin
          if (redir) begin
            pc    <= target;
            state <= FETCH;
          end else if (accept) begin
            pc    <= pc + PC_ONE;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // When ID takes the current instruction and nothing new arrives, IF/ID empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_instr    <= '0;
      if_id_pc       <= '0;
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
    end else if (redir) begin
      if_id_valid <= 1'b0;
    end else if (load) begin
      if_id_instr    <= load_instr;
      if_id_pc       <= pc;
      if_id_pc_plus1 <= pc + PC_ONE;
      if_id_valid    <= 1'b1;
    end else if (!id_stall) begin
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized stimulus, every
// cycle compared against a transaction-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        id_stall;
  logic        jump_valid;
  logic [12:0] jump_addr;
  logic        br_valid;
  logic [15:0] br_target;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus1;
  logic        if_id_valid;

  int errors = 0;
  int checks = 0;

  int mem_lat = 0;
  int wait_cnt = 0;
  bit rand_ack = 1'b0;

  // Reference model: pc, whether a request is in flight, a pending redirect
  // target for a request already issued, and a parked word.
  logic        m_started, m_req, m_pend, m_parked;
  logic [15:0] m_pc, m_ptgt, m_pdata;
  logic [15:0] m_instr, m_ipc, m_ipc1;
  logic        m_valid;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .br_valid(br_valid), .br_target(br_target),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus1(if_id_pc_plus1), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_req = 0; m_pend = 0; m_parked = 0;
    m_pc = 16'h0000; m_ptgt = 16'h0000; m_pdata = 16'h0000;
    m_instr = 16'h0000; m_ipc = 16'h0000; m_ipc1 = 16'h0000; m_valid = 0;
  endtask

  task automatic model_update(input logic st, input logic jv, input logic [12:0] ja,
                              input logic bv, input logic [15:0] bt, input logic ack);
    logic        redir, acc, take;
    logic [15:0] tgt, t_data, t_pc;
    redir = bv | jv;
    tgt = bv ? bt : {m_ipc1[15:13], ja};
    acc = !st || !m_valid;
    take = 0; t_data = 16'h0000; t_pc = 16'h0000;
    if (!m_started) begin
      m_started = 1;
      m_req = 1;
      if (redir) m_pc = tgt;
    end else if (m_parked) begin
      if (redir) begin
        m_parked = 0; m_req = 1; m_pc = tgt;
      end else if (acc) begin
        take = 1; t_data = m_pdata; t_pc = m_pc;
        m_pc = m_pc + 16'd1; m_parked = 0; m_req = 1;
      end
    end else if (m_pend) begin
      if (redir) m_ptgt = tgt;
      if (ack) begin
        m_pc = m_ptgt; m_pend = 0;
      end
    end else if (redir) begin
      if (ack) m_pc = tgt;
      else begin
        m_pend = 1; m_ptgt = tgt;
      end
    end else if (ack) begin
      if (acc) begin
        take = 1; t_data = mem_word(m_pc); t_pc = m_pc;
        m_pc = m_pc + 16'd1;
      end else begin
        m_parked = 1; m_pdata = mem_word(m_pc); m_req = 0;
      end
    end
    if (redir) m_valid = 0;
    else if (take) begin
      m_instr = t_data; m_ipc = t_pc; m_ipc1 = t_pc + 16'd1; m_valid = 1;
    end else if (!st) m_valid = 0;
  endtask

  task automatic check_model();
    chk("req", 16'(imem_req), 16'(m_req));
    chk("addr", imem_addr, m_pc);
    chk("valid", 16'(if_id_valid), 16'(m_valid));
    chk("instr", if_id_instr, m_instr);
    chk("ifpc", if_id_pc, m_ipc);
    chk("ifpc1", if_id_pc_plus1, m_ipc1);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic st, input logic jv, input logic [12:0] ja,
                      input logic bv, input logic [15:0] bt);
    logic ack, req_before;
    id_stall = st; jump_valid = jv; jump_addr = ja;
    br_valid = bv; br_target = bt;
    if (rand_ack) ack = imem_req && ($urandom_range(0, 1) == 1);
    else ack = imem_req && (wait_cnt >= mem_lat);
    imem_ack = ack;
    imem_rdata = mem_word(imem_addr);
    #2;
    check_model();
    model_update(st, jv, ja, bv, bt, ack);
    req_before = imem_req;
    @(posedge clk);
    #1;
    wait_cnt = (req_before && !ack) ? wait_cnt + 1 : 0;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 13'h0, 1'b0, 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 0; imem_rdata = 16'h0; id_stall = 0;
    jump_valid = 0; jump_addr = 13'h0; br_valid = 0; br_target = 16'h0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", 16'(imem_req), 16'h0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", 16'(if_id_valid), 16'h0);
    chk("rst_ifpc", if_id_pc, 16'h0000);
    rst = 1'b0;

    // Sequential zero-wait fetch
    mem_lat = 0;
    idle_step();
    chk("first_req", 16'(imem_req), 16'h1);
    chk("first_addr", imem_addr, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      idle_step();
      chk("seq_pc", if_id_pc, 16'(i));
      chk("seq_instr", if_id_instr, mem_word(16'(i)));
      chk("seq_valid", 16'(if_id_valid), 16'h1);
    end

    // Stall with ack for pc=3 -> skid, then release
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 13'h0, 1'b0, 16'h0);
      chk("stall_req", 16'(imem_req), 16'h0);
      chk("stall_pc", if_id_pc, 16'h0002);
    end
    idle_step();
    chk("skid_pc", if_id_pc, 16'h0003);
    chk("skid_instr", if_id_instr, mem_word(16'h0003));
    chk("skid_next", imem_addr, 16'h0004);
    idle_step();
    chk("after_skid", if_id_pc, 16'h0004);

    // Jump using upper pc_plus1 bits
    step(1'b0, 1'b0, 13'h0, 1'b1, 16'h4004);
    idle_step();
    chk("pre_jump", if_id_pc_plus1, 16'h4005);
    step(1'b0, 1'b1, 13'h0123, 1'b0, 16'h0);
    chk("jump_flush", 16'(if_id_valid), 16'h0);
    chk("jump_addr", imem_addr, 16'h4123);
    idle_step();
    chk("jump_ifpc", if_id_pc, 16'h4123);

    // Branch while a 3-cycle request is outstanding
    mem_lat = 2;
    step(1'b0, 1'b0, 13'h0, 1'b1, 16'h0040);
    chk("drain_addr0", imem_addr, 16'h4124);
    idle_step();
    chk("drain_addr1", imem_addr, 16'h4124);
    idle_step();
    chk("drain_done", imem_addr, 16'h0040);
    chk("drain_flush", 16'(if_id_valid), 16'h0);
    for (int i = 0; i < 3; i++) idle_step();
    chk("br_ifpc", if_id_pc, 16'h0040);

    // Branch beats jump
    mem_lat = 0;
    step(1'b0, 1'b1, 13'h1FFF, 1'b1, 16'h0080);
    chk("br_prio", imem_addr, 16'h0080);

    // PC wrap
    step(1'b0, 1'b0, 13'h0, 1'b1, 16'hFFFF);
    idle_step();
    chk("wrap_addr", imem_addr, 16'h0000);
    chk("wrap_ifpc", if_id_pc, 16'hFFFF);
    chk("wrap_ifpc1", if_id_pc_plus1, 16'h0000);

    // Async reset during DRAIN
    mem_lat = 3;
    idle_step();
    step(1'b0, 1'b0, 13'h0, 1'b1, 16'h0100);
    chk("pre_rst_req", 16'(imem_req), 16'h1);
    id_stall = 0; jump_valid = 0; br_valid = 0; imem_ack = 0;
    #1 rst = 1'b1;
    #1;
    chk("arst_req", 16'(imem_req), 16'h0);
    chk("arst_addr", imem_addr, 16'h0000);
    chk("arst_valid", 16'(if_id_valid), 16'h0);
    chk("arst_instr", if_id_instr, 16'h0000);
    chk("arst_ifpc", if_id_pc, 16'h0000);
    chk("arst_ifpc1", if_id_pc_plus1, 16'h0000);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cnt = 0;
    mem_lat = 0;
    idle_step();
    idle_step();
    chk("restart_pc", if_id_pc, 16'h0000);

    // Randomized run
    rand_ack = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, 13'($urandom),
           $urandom_range(0, 11) == 0, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
